// File: rtl/tmds_decoder_aligner.sv
// TMDS receive channel: finds the 10-bit word boundary from control tokens,
// then decodes aligned words into pixel bytes or control bits.
module tmds_decoder_aligner #(
  parameter int CTRL_RUN = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_tmds_raw,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_de,
  output logic       o_locked,
  output logic [3:0] o_phase,
  output logic       o_err
);

  localparam int DW = $clog2(TIMEOUT);
  localparam int RW = $clog2(CTRL_RUN + 1);

  typedef enum logic [0:0] {SEARCH, LOCKED} state_t;

  state_t        state, state_next;
  logic [9:0]    prev_q, stage_a, aligned;
  logic          a_valid;
  logic [19:0]   window;
  logic [4:0]    shift;
  logic [3:0]    phase, phase_next;
  logic [RW-1:0] run_cnt, run_next;
  logic [DW-1:0] dwell_cnt, dwell_next, idle_cnt, idle_next;
  logic          phase_step, lost, is_token, out_locked;
  logic [1:0]    tok_code;
  logic [7:0]    d, dec;

  assign window  = {i_tmds_raw, prev_q};
  assign shift   = {1'b0, phase};
  assign aligned = window[shift +: 10];
  assign o_phase = phase;

  always_comb begin
    is_token = 1'b1;
    tok_code = 2'b00;
    case (stage_a)
      10'b1101010100: tok_code = 2'b00;
      10'b0010101011: tok_code = 2'b01;
      10'b0101010100: tok_code = 2'b10;
      10'b1010101011: tok_code = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d      = stage_a[9] ? ~stage_a[7:0] : stage_a[7:0];
    dec    = 8'h00;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = stage_a[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    run_next   = run_cnt;
    dwell_next = dwell_cnt;
    idle_next  = idle_cnt;
    phase_step = 1'b0;
    lost       = 1'b0;
    case (state)
      SEARCH: begin
        if (a_valid) begin
          if (is_token) begin
            run_next = (run_cnt == RW'(CTRL_RUN)) ? run_cnt : run_cnt + 1'b1;
          end else begin
            run_next = '0;
          end
        end
        dwell_next = dwell_cnt + 1'b1;
        // A completed token run wins over a dwell timeout in the same cycle.
        if (run_next == RW'(CTRL_RUN)) begin
          state_next = LOCKED;
          idle_next  = '0;
          run_next   = '0;
          dwell_next = '0;
        end else if (dwell_cnt == DW'(TIMEOUT - 1)) begin
          phase_next = (phase == 4'd9) ? 4'd0 : phase + 4'd1;
          run_next   = '0;
          dwell_next = '0;
          phase_step = 1'b1;
        end
      end
      LOCKED: begin
        if (idle_cnt == DW'(TIMEOUT - 1)) begin
          state_next = SEARCH;
          lost       = 1'b1;
          run_next   = '0;
          dwell_next = '0;
          idle_next  = '0;
        end else begin
          idle_next = is_token ? '0 : idle_cnt + 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  assign out_locked = (state == LOCKED) && !lost;

  // Stage A loaded with the old phase is stale once the phase moves.
  always_ff @(posedge i_clk) begin
    prev_q <= i_tmds_raw;
    if (i_rst) begin
      state     <= SEARCH;
      phase     <= 4'd0;
      run_cnt   <= '0;
      dwell_cnt <= '0;
      idle_cnt  <= '0;
      stage_a   <= 10'd0;
      a_valid   <= 1'b0;
    end else begin
      state     <= state_next;
      phase     <= phase_next;
      run_cnt   <= run_next;
      dwell_cnt <= dwell_next;
      idle_cnt  <= idle_next;
      stage_a   <= aligned;
      a_valid   <= !phase_step;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data   <= 8'h00;
      o_ctrl   <= 2'b00;
      o_de     <= 1'b0;
      o_locked <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_err    <= lost;
      o_locked <= out_locked;
      if (!out_locked) begin
        o_de   <= 1'b0;
        o_ctrl <= 2'b00;
        o_data <= 8'h00;
      end else if (is_token) begin
        o_de   <= 1'b0;
        o_ctrl <= tok_code;
        o_data <= 8'h00;
      end else begin
        o_de   <= 1'b1;
        o_data <= dec;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder_aligner.sv
// Testbench for tmds_decoder_aligner: bit-stream stimulus at chosen offsets,
// checked cycle by cycle against a behavioural model and scenario checks.
module tb_tmds_decoder_aligner;

  localparam int CR  = 4;
  localparam int TMO = 16;

  logic       clk;
  logic       i_rst;
  logic [9:0] i_tmds_raw;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de, o_locked, o_err;
  logic [3:0] o_phase;
  logic [16:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;
  int enc_cnt  = 0;
  bit bitq[$];

  // Behavioural model state
  int         m_phase, m_run, m_dwell, m_idle;
  bit         m_locked, m_skip;
  logic [9:0] m_prev, m_a;
  logic [7:0] m_data;
  logic [1:0] m_ctrl;
  bit         m_de, m_lk, m_err;

  tmds_decoder_aligner #(.CTRL_RUN(CR), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_tmds_raw(i_tmds_raw),
    .o_data(o_data), .o_ctrl(o_ctrl), .o_de(o_de),
    .o_locked(o_locked), .o_phase(o_phase), .o_err(o_err)
  );

  assign dut_vec = {o_locked, o_err, o_de, o_ctrl, o_data, o_phase};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model_vec();
    return {m_lk, m_err, m_de, m_ctrl, m_data, 4'(m_phase)};
  endfunction

  function automatic logic [9:0] tok_word(input int c);
    case (c)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic int token_code(input logic [9:0] w);
    for (int c = 0; c < 4; c++) if (w == tok_word(c)) return c;
    return -1;
  endfunction

  // Inverse of the transition-minimising step, written as whole-byte XOR.
  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] q, x;
    q = w[9] ? ~w[7:0] : w[7:0];
    x = q ^ {q[6:0], 1'b0};
    return w[8] ? x : (x ^ 8'hFE);
  endfunction

  // Reference TMDS encoder with running disparity.
  function automatic logic [9:0] enc_data(input logic [7:0] b);
    int n1, n1q, n0q;
    logic [8:0] qm;
    logic [9:0] q;
    n1 = $countones(b);
    qm = '0;
    qm[0] = b[0];
    if (n1 > 4 || (n1 == 4 && b[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += (qm[8] ? 0 : -2) + n1q - n0q;
    end
    return q;
  endfunction

  function automatic void push_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) bitq.push_back(w[i]);
  endfunction

  function automatic void push_ctrl(input int c);
    enc_cnt = 0;
    push_word(tok_word(c));
  endfunction

  function automatic void push_rand_bits(input int n);
    for (int i = 0; i < n; i++) bitq.push_back(1'($urandom_range(0, 1)));
  endfunction

  function automatic logic [9:0] pop_raw();
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = bitq.pop_front();
    return r;
  endfunction

  // One clock of the reference behaviour, from the rules of the block.
  task automatic model_step(input logic [9:0] raw, input bit rst);
    int tok, nrun;
    bit lost;
    logic [19:0] win;
    logic [9:0] next_a;
    win = {raw, m_prev};
    if (rst) begin
      m_phase = 0; m_locked = 0; m_run = 0; m_dwell = 0; m_idle = 0; m_skip = 1;
      m_a = '0; m_de = 0; m_ctrl = '0; m_data = '0; m_lk = 0; m_err = 0;
      m_prev = raw;
      return;
    end
    tok   = token_code(m_a);
    lost  = m_locked && (m_idle == TMO - 1);
    m_err = lost;
    m_lk  = m_locked && !lost;
    if (!m_lk) begin
      m_de = 0; m_ctrl = '0; m_data = '0;
    end else if (tok >= 0) begin
      m_de = 0; m_ctrl = 2'(tok); m_data = '0;
    end else begin
      m_de = 1; m_data = ref_decode(m_a);
    end
    next_a = 10'(win >> m_phase);
    if (m_locked) begin
      if (lost) begin
        m_locked = 0; m_run = 0; m_dwell = 0; m_idle = 0;
      end else begin
        m_idle = (tok >= 0) ? 0 : m_idle + 1;
      end
      m_skip = 0;
    end else begin
      nrun = m_skip ? m_run : ((tok >= 0) ? ((m_run < CR) ? m_run + 1 : CR) : 0);
      m_skip = 0;
      if (nrun == CR) begin
        m_locked = 1; m_idle = 0; m_run = 0; m_dwell = 0;
      end else if (m_dwell == TMO - 1) begin
        m_phase = (m_phase + 1) % 10; m_run = 0; m_dwell = 0; m_skip = 1;
      end else begin
        m_run = nrun; m_dwell++;
      end
    end
    m_a    = next_a;
    m_prev = raw;
  endtask

  task automatic step(input logic [9:0] raw, input bit rst);
    @(negedge clk);
    i_tmds_raw = raw;
    i_rst      = rst;
    @(posedge clk);
    model_step(raw, rst);
    #1;
  endtask

  task automatic reset_dut();
    bitq.delete();
    enc_cnt = 0;
    repeat (2) step(10'd0, 1'b1);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      step(10'($urandom), (k < 3));
      n_checks++;
      if (dut_vec !== 17'd0) begin
        n_fail++;
        $display("[TB] FAIL reset cyc %0d: outputs=%h required=%h", k, dut_vec, 17'd0);
      end
    end
  endtask

  task automatic test_phase0();
    logic [9:0] w;
    reset_dut();
    for (int k = 1; k <= 16; k++) begin
      w = (k <= 8 || k > 10) ? tok_word(0) : ((k == 9) ? 10'h100 : 10'h200);
      step(w, 1'b0);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL phase0_model cyc %0d: dut=%h model=%h", k, dut_vec, model_vec());
      end
      if (k == 6 || k == 7) begin
        n_checks++;
        if (o_locked !== (k == 7)) begin
          n_fail++;
          $display("[TB] FAIL phase0_lock cyc %0d: o_locked=%b required=%b", k, o_locked, (k == 7));
        end
      end
      if (k >= 10 && k <= 12) begin
        n_checks++;
        if ({o_de, o_ctrl, o_data} !== ((k == 10) ? 11'h000 : (k == 11) ? 11'h400 : 11'h4FF)) begin
          n_fail++;
          $display("[TB] FAIL phase0_decode cyc %0d: de=%b ctrl=%b data=%h", k, o_de, o_ctrl, o_data);
        end
      end
    end
  endtask

  task automatic test_offset3();
    int phases[$];
    logic [7:0] got[$];
    int cyc, lock_cyc, lock_phase;
    reset_dut();
    push_rand_bits(3);
    for (int r = 0; r < 10; r++) begin
      for (int t = 0; t < 8; t++) push_ctrl(0);
      push_word(10'h100);
      push_word(10'h200);
    end
    push_ctrl(0); push_ctrl(0);
    cyc = 0; lock_cyc = -1; lock_phase = -1;
    phases.push_back(0);
    while (bitq.size() >= 10) begin
      step(pop_raw(), 1'b0);
      cyc++;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL offset3_model cyc %0d: dut=%h model=%h", cyc, dut_vec, model_vec());
      end
      if (lock_cyc < 0 && o_locked === 1'b1) begin
        lock_cyc = cyc; lock_phase = o_phase;
      end
      if (lock_cyc < 0 && int'(o_phase) != phases[$]) phases.push_back(int'(o_phase));
      if (o_locked === 1'b1 && o_de === 1'b1) got.push_back(o_data);
    end
    n_checks++;
    if (lock_cyc < 1 || lock_cyc > 4 * TMO + 8 || lock_phase != 3) begin
      n_fail++;
      $display("[TB] FAIL offset3_lock: lock cycle %0d at phase %0d, required <=%0d at phase 3", lock_cyc, lock_phase, 4 * TMO + 8);
    end
    n_checks++;
    if (phases.size() != 4 || phases[0] != 0 || phases[1] != 1 || phases[2] != 2 || phases[3] != 3) begin
      n_fail++;
      $display("[TB] FAIL offset3_phases: saw %0d phases ending at %0d, required 0,1,2,3", phases.size(), phases[$]);
    end
    n_checks++;
    if (got.size() < 10) begin
      n_fail++;
      $display("[TB] FAIL offset3_count: %0d data words, required at least 10", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== ((i % 2) ? 8'hFF : 8'h00)) begin
        n_fail++;
        $display("[TB] FAIL offset3_data idx %0d: got %h required %h", i, got[i], (i % 2) ? 8'hFF : 8'h00);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [7:0] got[$];
    logic [1:0] ctl[$];
    int cyc, errs;
    bit prev_de;
    reset_dut();
    push_rand_bits(7);
    for (int i = 0; i < 150; i++) push_ctrl(0);
    for (int g = 0; g < 32; g++) begin
      for (int j = 0; j < 8; j++) push_word(enc_data(8'(g * 8 + j)));
      push_ctrl(g % 4);
    end
    for (int i = 0; i < 6; i++) push_ctrl(0);
    cyc = 0; errs = 0; prev_de = 0;
    while (bitq.size() >= 10) begin
      step(pop_raw(), 1'b0);
      cyc++;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL roundtrip_model cyc %0d: dut=%h model=%h", cyc, dut_vec, model_vec());
      end
      if (o_err === 1'b1) errs++;
      if (o_locked === 1'b1 && o_de === 1'b1) got.push_back(o_data);
      if (o_locked === 1'b1 && o_de === 1'b0 && prev_de) ctl.push_back(o_ctrl);
      prev_de = (o_de === 1'b1);
    end
    n_checks++;
    if (errs != 0 || o_phase !== 4'd7 || got.size() != 256 || ctl.size() != 32) begin
      n_fail++;
      $display("[TB] FAIL roundtrip_summary: err=%0d phase=%0d bytes=%0d ctrls=%0d, required 0/7/256/32", errs, o_phase, got.size(), ctl.size());
    end
    for (int i = 0; i < got.size() && i < 256; i++) begin
      n_checks++;
      if (got[i] !== 8'(i)) begin
        n_fail++;
        $display("[TB] FAIL roundtrip_byte idx %0d: got %h required %h", i, got[i], 8'(i));
      end
    end
    for (int i = 0; i < ctl.size() && i < 32; i++) begin
      n_checks++;
      if (ctl[i] !== 2'(i % 4)) begin
        n_fail++;
        $display("[TB] FAIL roundtrip_ctrl idx %0d: got %0d required %0d", i, ctl[i], i % 4);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    int off, cyc, errs;
    off = $urandom_range(1, 8);
    reset_dut();
    push_rand_bits(off);
    for (int i = 0; i < (off + 1) * TMO + 12; i++) push_ctrl(0);
    for (int i = 0; i < TMO + 2; i++) push_word(enc_data(8'($urandom)));
    for (int i = 0; i < 12; i++) push_ctrl(0);
    cyc = 0; errs = 0;
    while (bitq.size() >= 10) begin
      step(pop_raw(), 1'b0);
      cyc++;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL loss_model cyc %0d: dut=%h model=%h", cyc, dut_vec, model_vec());
      end
      if (o_err === 1'b1) begin
        errs++;
        n_checks++;
        if (o_locked !== 1'b0 || o_phase !== 4'(off)) begin
          n_fail++;
          $display("[TB] FAIL loss_err_state: locked=%b phase=%0d, required 0 and %0d", o_locked, o_phase, off);
        end
      end
    end
    n_checks++;
    if (errs != 1 || o_locked !== 1'b1 || o_phase !== 4'(off)) begin
      n_fail++;
      $display("[TB] FAIL loss_relock: err cycles=%0d locked=%b phase=%0d, required 1/1/%0d", errs, o_locked, o_phase, off);
    end
  endtask

  task automatic test_reset_mid_lock();
    reset_dut();
    push_rand_bits(5);
    for (int i = 0; i < 6 * TMO + 12; i++) push_ctrl(0);
    while (bitq.size() >= 10) step(pop_raw(), 1'b0);
    n_checks++;
    if (o_locked !== 1'b1 || o_phase !== 4'd5) begin
      n_fail++;
      $display("[TB] FAIL midreset_pre: locked=%b phase=%0d, required 1 and 5", o_locked, o_phase);
    end
    step(tok_word(0), 1'b1);
    n_checks++;
    if (o_locked !== 1'b0 || o_phase !== 4'd0 || o_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midreset_post: locked=%b phase=%0d err=%b, required 0/0/0", o_locked, o_phase, o_err);
    end
    step(tok_word(0), 1'b0);
  endtask

  task automatic test_random();
    int n;
    reset_dut();
    push_rand_bits($urandom_range(0, 9));
    while (bitq.size() < 3000) begin
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++) push_ctrl($urandom_range(0, 3));
      end else begin
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) push_word(enc_data(8'($urandom)));
      end
    end
    n = 0;
    while (bitq.size() >= 10) begin
      step(pop_raw(), 1'b0);
      n++;
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL random_model cyc %0d: dut=%h model=%h", n, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst      = 1'b1;
    i_tmds_raw = 10'd0;
    test_reset();
    test_phase0();
    test_offset3();
    test_roundtrip();
    test_loss_of_lock();
    test_reset_mid_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
